// File: rtl/drv_dac128s085.sv
//------------------------------------------------------------------------------
// drv_dac128s085 - SPI streamer for the TI DAC128S085; option macro DAC_SIMUL_UPDATE_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module drv_dac128s085 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] dac1,
  input  logic [11:0] dac2,
  input  logic [11:0] dac3,
  input  logic [11:0] dac4,
  input  logic [11:0] dac5,
  input  logic [11:0] dac6,
  input  logic [11:0] dac7,
  input  logic [11:0] dac8,
  input  logic [31:0] sclk_div,
  input  logic [31:0] sample_delay,
  output logic        SYNC,
  output logic        SCLK,
  output logic        DIN
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CH   = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

`ifdef DAC_SIMUL_UPDATE_EN
  localparam logic [15:0] INIT_WORD = 16'h8000;
  localparam logic [15:0] UPD_WORD  = 16'hA0FF;
`else
  localparam logic [15:0] INIT_WORD = 16'h9000;
`endif

  logic [2:0]  state, state_next, end_state;
  logic [11:0] shadow [8];
  logic [2:0]  ch_cnt, ch_next;
  logic [31:0] wait_cnt, half_cnt, half_lim;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg, frame_word;
  logic        active, in_gap, half_end, frame_done, frame_start, load_shadow;

  assign ch_next     = ch_cnt + 3'd1;
  assign half_end    = (half_cnt == half_lim - 32'd1);
  // The gap is two half-periods; bit_cnt[0] marks the second one.
  assign frame_done  = active && in_gap && half_end && bit_cnt[0];
  assign end_state   = (sample_delay == 32'd0) ? S_LOAD : S_WAIT;
  assign load_shadow = (state_next == S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT: if (frame_done) state_next = S_LOAD;
      S_LOAD: state_next = S_CH;
      S_CH:   if (frame_done && ch_cnt == 3'd7)
`ifdef DAC_SIMUL_UPDATE_EN
                state_next = S_UPD;
`else
                state_next = end_state;
`endif
      S_UPD:  if (frame_done) state_next = end_state;
      S_WAIT: if (wait_cnt == 32'd0) state_next = S_LOAD;
      default: state_next = S_INIT;
    endcase
  end

  // Back-to-back frames start on the same edge the previous gap ends.
  always_comb begin
    frame_start = 1'b0;
    frame_word  = INIT_WORD;
    case (state)
      S_INIT: frame_start = !active;
      S_LOAD: begin
        frame_start = 1'b1;
        frame_word  = {1'b0, 3'd0, shadow[0]};
      end
      S_CH: if (frame_done) begin
        if (state_next == S_CH) begin
          frame_start = 1'b1;
          frame_word  = {1'b0, ch_next, shadow[ch_next]};
        end
`ifdef DAC_SIMUL_UPDATE_EN
        else begin
          frame_start = 1'b1;
          frame_word  = UPD_WORD;
        end
`endif
      end
      default: frame_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
      ch_cnt   <= '0;
      wait_cnt <= '0;
    end else begin
      if (load_shadow) begin
        shadow[0] <= dac1; shadow[1] <= dac2; shadow[2] <= dac3; shadow[3] <= dac4;
        shadow[4] <= dac5; shadow[5] <= dac6; shadow[6] <= dac7; shadow[7] <= dac8;
      end
      if (state == S_LOAD)
        ch_cnt <= '0;
      else if (state == S_CH && frame_done)
        ch_cnt <= ch_next;
      if (state != S_WAIT && state_next == S_WAIT)
        wait_cnt <= sample_delay - 32'd1;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SYNC     <= 1'b1;
      SCLK     <= 1'b1;
      DIN      <= 1'b0;
      active   <= 1'b0;
      in_gap   <= 1'b0;
      shreg    <= '0;
      half_cnt <= '0;
      half_lim <= 32'd1;
      bit_cnt  <= '0;
    end else if (frame_start) begin
      SYNC     <= 1'b0;
      SCLK     <= 1'b1;
      DIN      <= frame_word[15];
      shreg    <= {frame_word[14:0], 1'b0};
      active   <= 1'b1;
      in_gap   <= 1'b0;
      half_cnt <= '0;
      half_lim <= (sclk_div == 32'd0) ? 32'd1 : sclk_div;
      bit_cnt  <= '0;
    end else if (active) begin
      if (!half_end) begin
        half_cnt <= half_cnt + 32'd1;
      end else begin
        half_cnt <= '0;
        if (in_gap) begin
          if (bit_cnt[0]) begin
            active  <= 1'b0;
            in_gap  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= 4'd1;
          end
        end else if (SCLK) begin
          SCLK <= 1'b0;
        end else if (bit_cnt == 4'd15) begin
          SCLK    <= 1'b1;
          SYNC    <= 1'b1;
          DIN     <= 1'b0;
          in_gap  <= 1'b1;
          bit_cnt <= '0;
        end else begin
          SCLK    <= 1'b1;
          DIN     <= shreg[15];
          shreg   <= {shreg[14:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_drv_dac128s085.sv
//------------------------------------------------------------------------------
// tb_drv_dac128s085 - randomized self-checking bench for drv_dac128s085. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_drv_dac128s085;

`ifdef DAC_SIMUL_UPDATE_EN
  localparam logic [15:0] INIT_W = 16'h8000;
`else
  localparam logic [15:0] INIT_W = 16'h9000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] dac [8];
  logic [11:0] snap [8];
  logic [31:0] sclk_div, sample_delay;
  logic        SYNC, SCLK, DIN;

  always #5 clk = ~clk;

  drv_dac128s085 dut (
    .clk(clk), .rst_n(rst_n),
    .dac1(dac[0]), .dac2(dac[1]), .dac3(dac[2]), .dac4(dac[3]),
    .dac5(dac[4]), .dac6(dac[5]), .dac7(dac[6]), .dac8(dac[7]),
    .sclk_div(sclk_div), .sample_delay(sample_delay),
    .SYNC(SYNC), .SCLK(SCLK), .DIN(DIN)
  );

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          len;
    int          gap;
  } frame_t;

  frame_t fq[$];
  int checks = 0;
  int failures = 0;

  // Pin-level receiver: shifts DIN on SCLK falls inside SYNC-low windows.
  int          hi_cnt = 0, lo_cnt = 0, nb = 0, gap_b = 0;
  logic        in_frame = 1'b0, prev_sclk = 1'b1;
  logic [15:0] shift_w = '0;
  frame_t      mon_f;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      hi_cnt    = 0;
      prev_sclk = 1'b1;
    end else begin
      if (SYNC === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1'b1; lo_cnt = 0; nb = 0; shift_w = '0; gap_b = hi_cnt;
        end
        lo_cnt++;
        if (prev_sclk === 1'b1 && SCLK === 1'b0) begin
          shift_w = {shift_w[14:0], DIN};
          nb++;
        end
      end else begin
        if (in_frame) begin
          mon_f.word = shift_w; mon_f.nbits = nb; mon_f.len = lo_cnt; mon_f.gap = gap_b;
          fq.push_back(mon_f);
          in_frame = 1'b0;
          hi_cnt   = 0;
        end
        hi_cnt++;
      end
      prev_sclk = SCLK;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] chan_word(input int ch, input logic [11:0] code);
    return 16'(ch * 4096 + int'(code));
  endfunction

  function automatic int hval(input logic [31:0] v);
    return (v == 32'd0) ? 1 : int'(v);
  endfunction

  // gap < 0: frame directly after reset release, SYNC must fall within one clock.
  task automatic expect_frame(input string tag, input logic [15:0] w, input int h, input int gap);
    frame_t f;
    int waited = 0;
    while (fq.size() == 0 && waited < 4000) begin
      @(posedge clk);
      waited++;
    end
    if (fq.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    f = fq.pop_front();
    check({tag, "_word"}, 32'(f.word), 32'(w));
    check({tag, "_nbits"}, f.nbits, 16);
    check({tag, "_synclow"}, f.len, 32 * h);
    if (gap < 0) check({tag, "_start"}, 32'(f.gap <= 1), 32'd1);
    else         check({tag, "_gap"}, f.gap, gap);
  endtask

  task automatic rest_of_cycle(input string tag, input int h);
    for (int ch = 1; ch < 8; ch++)
      expect_frame($sformatf("%s_ch%0d", tag, ch), chan_word(ch, snap[ch]), h, 2 * h);
`ifdef DAC_SIMUL_UPDATE_EN
    expect_frame({tag, "_upd"}, 16'hA0FF, h, 2 * h);
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h, h_prev, d_prev;
    sclk_div     = 32'd8;
    sample_delay = 32'd0;
    for (int i = 0; i < 8; i++) dac[i] = 12'((1 << (i + 1)) - 1);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sync", 32'(SYNC), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd1);
    check("rst_din",  32'(DIN),  32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    expect_frame("init", INIT_W, 8, -1);

    // Cycle 1: dac3 changes during channel B and must not leak into this cycle.
    snap = dac;
    expect_frame("c1_ch0", chan_word(0, snap[0]), 8, 17);
    sample_delay = 32'd100;
    repeat (40) @(posedge clk);
    dac[2] = 12'h5A5;
    rest_of_cycle("c1", 8);

    snap = dac;
    expect_frame("c2_ch0", chan_word(0, snap[0]), 8, 117);
    sample_delay = 32'd0;
    rest_of_cycle("c2", 8);

    snap = dac;
    expect_frame("c3_ch0", chan_word(0, snap[0]), 8, 17);
    d_prev = $urandom_range(8, 30);
    sample_delay = d_prev;
    rest_of_cycle("c3", 8);
    h_prev = 8;
    h = 8;

    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 8; i++) dac[i] = 12'($urandom);
      sclk_div = (c == 0) ? 32'd0 : 32'($urandom_range(0, 4));
      h = hval(sclk_div);
      snap = dac;
      expect_frame($sformatf("r%0d_ch0", c), chan_word(0, snap[0]), h, 2 * h_prev + 1 + d_prev);
      d_prev = $urandom_range(8, 30);
      sample_delay = d_prev;
      rest_of_cycle($sformatf("r%0d", c), h);
      h_prev = h;
    end

    // Abort a frame with reset, then expect a clean restart from the mode frame.
    snap = dac;
    expect_frame("pre_rst_ch0", chan_word(0, snap[0]), h, 2 * h_prev + 1 + d_prev);
    for (int i = 0; i < 200 && SYNC !== 1'b0; i++) @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_sync", 32'(SYNC), 32'd1);
    check("abort_sclk", 32'(SCLK), 32'd1);
    check("abort_din",  32'(DIN),  32'd0);
    repeat (3) @(posedge clk);
    fq.delete();
    sclk_div     = 32'd0;
    sample_delay = 32'd0;
    for (int i = 0; i < 8; i++) dac[i] = 12'($urandom);
    @(negedge clk);
    #1 rst_n = 1'b1;

    expect_frame("post_rst_init", INIT_W, 1, -1);
    snap = dac;
    expect_frame("post_rst_ch0", chan_word(0, snap[0]), 1, 3);
    rest_of_cycle("post_rst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
